// File: rtl/avr_dmem_arbiter.sv
// Data-memory arbiter between CPU and aux port; DMEM_ARB_RR_EN selects round-robin over CPU priority.
// Grant/mem_* are combinational, read data returns the cycle after the grant; refused requesters hold.
`timescale 1ns/1ps

module avr_dmem_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic              aux_lock,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_OWN  = 2'd1,
    AUX_OWN  = 2'd2,
    AUX_LOCK = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              cpu_win, aux_win;
  logic              cpu_rd_q, cpu_rd_d;
  logic              aux_rd_q, aux_rd_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;

`ifndef DMEM_ARB_RR_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt_q, starve_cnt_d;
`endif

  always_comb begin
    cpu_win = 1'b0;
    aux_win = 1'b0;
    if (state_q == AUX_LOCK && aux_req) begin
      aux_win = 1'b1;
    end else begin
`ifdef DMEM_ARB_RR_EN
      if (cpu_req && aux_req) begin
        aux_win = (state_q == CPU_OWN);
        cpu_win = (state_q != CPU_OWN);
      end else begin
        cpu_win = cpu_req;
        aux_win = aux_req;
      end
`else
      // A CPU held off by the starvation limit still wins if aux has gone away.
      cpu_win = cpu_req && ((starve_cnt_q < LIMIT) || !aux_req);
      aux_win = aux_req && !cpu_win;
`endif
    end
  end

  always_comb begin
    state_d = IDLE;
    if (cpu_win)      state_d = CPU_OWN;
    else if (aux_win) state_d = aux_lock ? AUX_LOCK : AUX_OWN;
`ifndef DMEM_ARB_RR_EN
    starve_cnt_d = starve_cnt_q;
    if (!aux_req || aux_win)   starve_cnt_d = 4'd0;
    else if (starve_cnt_q < LIMIT) starve_cnt_d = starve_cnt_q + 4'd1;
`endif
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (aux_win) begin
      mem_addr  = aux_addr;
      mem_wdata = aux_wdata;
      mem_we    = aux_we;
    end else if (cpu_win) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_win;
  assign aux_gnt   = aux_win;

  // The owner tag doubles as rvalid; rdata follows memory while valid and holds otherwise.
  assign cpu_rd_d    = cpu_win & ~cpu_we;
  assign aux_rd_d    = aux_win & ~aux_we;
  assign cpu_rvalid  = cpu_rd_q;
  assign aux_rvalid  = aux_rd_q;
  assign cpu_rdata   = cpu_rd_q ? mem_rdata : cpu_rdata_q;
  assign aux_rdata   = aux_rd_q ? mem_rdata : aux_rdata_q;
  assign cpu_rdata_d = cpu_rdata;
  assign aux_rdata_d = aux_rdata;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      cpu_rd_q    <= 1'b0;
      aux_rd_q    <= 1'b0;
      cpu_rdata_q <= '0;
      aux_rdata_q <= '0;
`ifndef DMEM_ARB_RR_EN
      starve_cnt_q <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      cpu_rd_q    <= cpu_rd_d;
      aux_rd_q    <= aux_rd_d;
      cpu_rdata_q <= cpu_rdata_d;
      aux_rdata_q <= aux_rdata_d;
`ifndef DMEM_ARB_RR_EN
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

endmodule

// File: doc/avr_dmem_arbiter.md
Name: avr_dmem_arbiter

Overview:
Shares the single-port data memory between the CPU data port and an auxiliary requester (debug/DMA port).
- Picks one winner per cycle and drives the memory address, write-enable and write-data for that winner.
- Returns registered read data to the requester that issued the read.
- Generates the CPU stall.
- Sits between avr_cpu, the aux master and data_memory in the CPU top level.

Parameters:
- ADDR_W, 11, data memory address width (2048 bytes).
- DATA_W, 8, data width.
- STARVE_LIMIT, 3, consecutive cycles aux may be refused before it gets forced priority (1..15).

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- RST  input  1  asynchronous, active-low reset.
- cpu_req  input  1  CPU requests a memory access this cycle.
- cpu_we  input  1  CPU access is a write.
- cpu_addr  input  ADDR_W  CPU address.
- cpu_wdata  input  DATA_W  CPU write data.
- cpu_stall  output  1  CPU request refused this cycle; CPU holds its request.
- cpu_rvalid  output  1  cpu_rdata valid (cycle after a granted CPU read).
- cpu_rdata  output  DATA_W  CPU read data.
- aux_req  input  1  aux requests an access.
- aux_we  input  1  aux access is a write.
- aux_lock  input  1  aux asks to keep ownership after this access.
- aux_addr  input  ADDR_W  aux address.
- aux_wdata  input  DATA_W  aux write data.
- aux_gnt  output  1  aux access accepted this cycle.
- aux_rvalid  output  1  aux_rdata valid.
- aux_rdata  output  DATA_W  aux read data.
- mem_addr  output  ADDR_W  to data memory.
- mem_we  output  1  to data memory.
- mem_wdata  output  DATA_W  to data memory (top level drives the bidirectional bus when mem_we=1).
- mem_rdata  input  DATA_W  from data memory, valid one cycle after the address is sampled.

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE, starve_cnt=0.
  - cpu_rvalid=aux_rvalid=0; cpu_rdata=aux_rdata=0; the internal read-owner flag is cleared.
  - Combinational outputs with no requests: mem_we=0, mem_addr=0, mem_wdata=0, cpu_stall=0, aux_gnt=0.
  - Reset mid-access drops any pending read return; no rvalid is issued after reset.
- Grant is combinational from the requests and the registered state. At most one grant per cycle. Accesses are pipelined at one per cycle.
- FSM states and grant rule:
  - IDLE / CPU_OWN (CPU was last winner):
    - CPU wins if cpu_req and starve_cnt<STARVE_LIMIT.
    - Otherwise aux wins if aux_req.
  - AUX_OWN (aux was last winner, no lock): same rule as IDLE / CPU_OWN.
  - AUX_LOCK: aux wins unconditionally if aux_req; cpu_stall=cpu_req.
    - If aux_req=0 in AUX_LOCK, the lock is released: CPU may win this cycle, next state per the winner.
- State transitions:
  - Next state: CPU win -> CPU_OWN; aux win with aux_lock=1 -> AUX_LOCK; aux win with aux_lock=0 -> AUX_OWN; no request -> IDLE.
- Starvation counter (starve_cnt):
  - Cleared when aux is granted or aux_req=0.
  - Incremented (saturating at STARVE_LIMIT) when aux_req=1 and aux is refused.
  - With STARVE_LIMIT=3, aux waits at most 3 cycles.
- Output derivation:
  - cpu_stall = cpu_req & ~cpu_win.
  - aux_gnt = aux_win.
  - mem_* are the winner's signals; mem_we=0 when there is no winner.
- Read return:
  - A granted read (we=0) sets a registered owner tag.
  - Next cycle, the owner's rvalid=1 and its rdata=mem_rdata, registered into cpu_rdata/aux_rdata.
  - rdata holds its value when rvalid=0. Writes produce no rvalid.
- Back-to-back accesses:
  - Read then write to the same address from different requesters: the read returns the old data.
  - Write then read in consecutive cycles: the read returns the new data.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- When defined: strict round-robin replaces CPU-priority. On simultaneous requests the requester that did not win last goes first; starve_cnt is not built; AUX_LOCK still overrides.
- When undefined: CPU-priority with the starvation counter, exactly as in Behaviour.

Test Plan:
1. Reset release, CPU read of addr 0x010 preloaded 0xA5 -> mem_addr=0x010 the same cycle, cpu_stall=0, cpu_rvalid=1 and cpu_rdata=0xA5 the next cycle.
2. CPU and aux both request continuously (STARVE_LIMIT=3) -> CPU granted 3 cycles with aux refused, 4th cycle aux_gnt=1 and cpu_stall=1, then the pattern repeats.
3. Aux writes 0x3C to 0x7FF with aux_lock=1 for 4 cycles while CPU requests -> cpu_stall=1 for all 4; after lock release CPU is granted and reads 0x3C from 0x7FF.
4. Aux read granted, then RST=0 asserted the next cycle before the edge -> aux_rvalid stays 0; all outputs at reset values.
5. CPU write 0x11 to 0x020, aux read of 0x020 the next cycle -> aux_rvalid with aux_rdata=0x11; cpu_rvalid stays 0.
6. With DMEM_ARB_RR_EN defined, both requesting continuously -> grants alternate CPU/aux every cycle starting with aux after a CPU win.
